// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 front-end types for the instruction fetch path
//
// Purpose: common widths, reset PC default, fetch FSM state encoding and the
// instruction-buffer entry layout used by fetch_ctrl and fetch_fifo.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // RV32I without the C extension requires word-aligned fetch targets.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous instruction buffer of fetch_entry_t entries
//
// Purpose: small power-of-two FIFO between the imem response and decode.
// The head is read straight out of storage registers, so a word pushed on
// one edge is visible at the head (o_valid=1) from the next cycle on.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_push, i_entry     write request and data (ignored when full without pop)
//   i_pop               remove head (ignored when empty)
//   i_flush             discard all entries; beats push and pop
//   o_valid, o_head     head present / head entry
//   o_count             number of stored entries
module fetch_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  fetch_entry_t               i_entry,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic                       o_valid,
    output fetch_entry_t               o_head,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    fetch_entry_t r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_push;
    logic w_pop;

    assign w_pop  = i_pop && (r_count != '0) && !i_flush;
    // When full, a simultaneous pop frees the slot being overwritten: with
    // wr_ptr == rd_ptr the new word lands in the old head's slot and becomes
    // the tail once rd_ptr advances.
    assign w_push = i_push && !i_flush && ((r_count != FULL_COUNT) || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - RV32I instruction fetch sequencer with buffered output
//
// Purpose: owns the PC, issues one imem request at a time, buffers returned
// words with their PC and hands them to decode with valid/ready. Handles
// execute-stage redirects, halt, and misaligned redirect targets.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   halt_i                       suppress new fetches while high
//   redirect_valid, redirect_pc  PC redirect from execute
//   imem_req, imem_addr          fetch request / word-aligned address
//   imem_gnt                     request accepted this cycle
//   imem_rvalid, imem_rdata      read response
//   inst_valid, inst_ready       decode handshake
//   inst, inst_pc                head instruction and its PC
//   fetch_fault, fault_pc        misaligned-target pulse / last bad target
module fetch_ctrl
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt_i,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_req_pc;
    logic         r_drop;
    logic         r_fault;
    logic [31:0]  r_fault_pc;

    logic         w_redir_bad;
    logic         w_redir_ok;
    logic         w_grant;
    logic         w_resp;
    logic         w_push;
    logic         w_pop;
    logic         w_fifo_valid;
    logic [CW-1:0] w_count;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;

    assign w_redir_bad = redirect_valid && is_misaligned(redirect_pc);
    assign w_redir_ok  = redirect_valid && !w_redir_bad;

    // The request is gated on buffer space so a response can always be
    // pushed; only one request is ever outstanding, and it is counted by
    // being in WAIT rather than REQ.
    assign imem_req  = !rst && (r_state == ST_REQ) && !halt_i
                       && (w_count < CW'(FIFO_DEPTH));
    assign imem_addr = r_pc;
    assign w_grant   = imem_req && imem_gnt;

    // Responses are only meaningful while a request is outstanding; anything
    // seen in REQ/HALT (e.g. left over from before a reset) is ignored.
    assign w_resp       = (r_state == ST_WAIT) && imem_rvalid;
    assign w_push       = w_resp && !r_drop && !redirect_valid;
    assign w_pop        = w_fifo_valid && inst_ready;
    assign w_push_entry = '{pc: r_req_pc, inst: imem_rdata};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_valid (w_fifo_valid),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_REQ;
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_drop     <= 1'b0;
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
        end else begin
            r_fault <= w_redir_bad;
            if (w_redir_bad) begin
                r_fault_pc <= redirect_pc;
            end

            if (w_grant) begin
                r_pc     <= r_pc + 32'd4;
                r_req_pc <= r_pc;
            end
            // An aligned redirect overrides the sequential increment.
            if (w_redir_ok) begin
                r_pc <= redirect_pc;
            end

            case (r_state)
                ST_REQ: begin
                    if (w_redir_bad) begin
                        r_drop  <= w_grant;
                        r_state <= ST_FAULT;
                    end else if (w_grant) begin
                        // Granted for the old PC in the redirect cycle: that
                        // word must not reach decode.
                        r_drop  <= w_redir_ok;
                        r_state <= ST_WAIT;
                    end else if (halt_i) begin
                        r_state <= ST_HALT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        // Response consumed now; a same-cycle redirect simply
                        // suppresses the push, so nothing is left to drop.
                        r_drop <= 1'b0;
                        if (w_redir_bad) begin
                            r_state <= ST_FAULT;
                        end else if (halt_i) begin
                            r_state <= ST_HALT;
                        end else begin
                            r_state <= ST_REQ;
                        end
                    end else begin
                        if (redirect_valid) begin
                            r_drop <= 1'b1;
                        end
                        if (w_redir_bad) begin
                            r_state <= ST_FAULT;
                        end
                    end
                end
                ST_HALT: begin
                    if (w_redir_bad) begin
                        r_state <= ST_FAULT;
                    end else if (!halt_i) begin
                        r_state <= ST_REQ;
                    end
                end
                ST_FAULT: begin
                    // r_drop here means a response is still in flight.
                    if (imem_rvalid && r_drop) begin
                        r_drop <= 1'b0;
                    end
                    if (w_redir_ok) begin
                        // Keep single-outstanding: finish swallowing the
                        // in-flight response before issuing the new fetch.
                        if (r_drop && !imem_rvalid) begin
                            r_state <= ST_WAIT;
                        end else begin
                            r_state <= ST_REQ;
                        end
                    end
                end
                default: r_state <= ST_REQ;
            endcase
        end
    end

    assign inst_valid  = w_fifo_valid;
    assign inst        = w_head.inst;
    assign inst_pc     = w_head.pc;
    assign fetch_fault = r_fault;
    assign fault_pc    = r_fault_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt_i;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    fetch_ctrl #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .halt_i         (halt_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_gnt = 0;
    int proto_viol = 0;
    int lat_min = 1;
    int lat_max = 1;

    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_inst[$];
    int          pop_cyc[$];
    logic [31:0] last_gnt_addr;

    logic        s_req, s_valid, s_fault;
    logic [31:0] s_addr, s_pc, s_fault_pc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // One clock cycle: inputs already set. Samples outputs mid-cycle, models
    // the memory (grant bookkeeping and delayed responses) and records pops.
    task automatic tick();
        #1;
        s_req      = imem_req;
        s_addr     = imem_addr;
        s_valid    = inst_valid;
        s_pc       = inst_pc;
        s_fault    = fetch_fault;
        s_fault_pc = fault_pc;
        if (imem_req && imem_gnt) begin
            if (mq_addr.size() != 0) proto_viol++;
            if (imem_addr[1:0] != 2'b00) proto_viol++;
            mq_addr.push_back(imem_addr);
            mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            last_gnt_addr = imem_addr;
            n_gnt++;
        end
        if (inst_valid && inst_ready && !redirect_valid && !rst) begin
            pop_pc.push_back(inst_pc);
            pop_inst.push_back(inst);
            pop_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (mq_due.size() != 0 && mq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
    endtask

    task automatic clear_pops();
        pop_pc.delete();
        pop_inst.delete();
        pop_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        halt_i = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        inst_ready = 1'b0;
        imem_gnt = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        clear_pops();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_gnt = 1'b1;
        inst_ready = 1'b1;
        repeat (3) tick();
        tick();
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", s_req); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", s_valid); end
        checks++; if (s_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", s_fault); end
        checks++; if (s_fault_pc !== 32'h0) begin errors++; $display("FAIL reset_fault_pc got=%h exp=0", s_fault_pc); end
        checks++; if (s_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got=%h exp=%h", s_addr, RESET_PC); end
        rst = 1'b0;
        tick();
        checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL first_req got=%b exp=1", s_req); end
        checks++; if (s_addr !== RESET_PC) begin errors++; $display("FAIL first_addr got=%h exp=%h", s_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        int t0;
        do_reset();
        lat_min = 1; lat_max = 1;
        imem_gnt = 1'b1;
        inst_ready = 1'b1;
        t0 = cyc;
        repeat (20) tick();
        checks++; if (pop_pc.size() != 9) begin errors++; $display("FAIL stream_count got=%0d exp=9", pop_pc.size()); end
        for (int i = 0; i < pop_pc.size(); i++) begin
            checks++;
            if (pop_pc[i] !== RESET_PC + 32'(4 * i) || pop_inst[i] !== memf(RESET_PC + 32'(4 * i))
                || pop_cyc[i] != t0 + 2 + 2 * i) begin
                errors++;
                $display("FAIL stream_%0d got pc=%h inst=%h cyc=%0d exp pc=%h inst=%h cyc=%0d", i,
                         pop_pc[i], pop_inst[i], pop_cyc[i] - t0, RESET_PC + 32'(4 * i),
                         memf(RESET_PC + 32'(4 * i)), 2 + 2 * i);
            end
        end
    endtask

    task automatic test_backpressure();
        int g0;
        do_reset();
        lat_min = 1; lat_max = 1;
        imem_gnt = 1'b1;
        inst_ready = 1'b0;
        g0 = n_gnt;
        repeat (10) tick();
        checks++; if (n_gnt - g0 != 2) begin errors++; $display("FAIL bp_grants got=%0d exp=2", n_gnt - g0); end
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL bp_req got=%b exp=0", s_req); end
        checks++; if (s_valid !== 1'b1 || s_pc !== 32'h0) begin errors++; $display("FAIL bp_head got v=%b pc=%h exp v=1 pc=0", s_valid, s_pc); end
        inst_ready = 1'b1;
        repeat (8) tick();
        checks++;
        if (pop_pc.size() < 3 || pop_pc[0] !== 32'h0 || pop_pc[1] !== 32'h4 || pop_pc[2] !== 32'h8) begin
            errors++;
            $display("FAIL bp_drain got n=%0d first=%h exp 0,4,8", pop_pc.size(),
                     pop_pc.size() != 0 ? pop_pc[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_wait();
        logic [31:0] pc_old;
        logic seen_old;
        do_reset();
        lat_min = 3; lat_max = 3;
        imem_gnt = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 60 && n_gnt < 3; i++) tick();
        for (int i = 0; i < 60 && !(mq_addr.size() != 0 && last_gnt_addr == 32'h8); i++) tick();
        checks++; if (mq_addr.size() == 0) begin errors++; $display("FAIL rw_setup got no outstanding request exp 1"); end
        pc_old = last_gnt_addr;
        clear_pops();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rw_flush got=%b exp=0", s_valid); end
        repeat (30) tick();
        checks++;
        if (pop_pc.size() < 3 || pop_pc[0] !== 32'h100 || pop_pc[1] !== 32'h104 || pop_inst[0] !== memf(32'h100)) begin
            errors++;
            $display("FAIL rw_target got n=%0d first=%h exp 100,104", pop_pc.size(),
                     pop_pc.size() != 0 ? pop_pc[0] : 32'hx);
        end
        seen_old = 1'b0;
        foreach (pop_pc[i]) if (pop_pc[i] == pc_old || pop_pc[i] == pc_old + 32'd4) seen_old = 1'b1;
        checks++; if (seen_old) begin errors++; $display("FAIL rw_stale got stale pc=%h delivered exp none", pc_old); end
    endtask

    task automatic test_fault();
        int g0;
        int req_seen;
        do_reset();
        lat_min = 1; lat_max = 1;
        imem_gnt = 1'b1;
        inst_ready = 1'b1;
        repeat (5) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
        clear_pops();
        g0 = n_gnt;
        tick();
        checks++; if (s_fault !== 1'b1 || s_fault_pc !== 32'h102) begin errors++; $display("FAIL fault_pulse got f=%b pc=%h exp f=1 pc=102", s_fault, s_fault_pc); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL fault_flush got=%b exp=0", s_valid); end
        tick();
        checks++; if (s_fault !== 1'b0 || s_fault_pc !== 32'h102) begin errors++; $display("FAIL fault_one_cycle got f=%b pc=%h exp f=0 pc=102", s_fault, s_fault_pc); end
        req_seen = 0;
        repeat (10) begin tick(); if (s_req) req_seen++; end
        checks++; if (req_seen != 0 || n_gnt != g0 || pop_pc.size() != 0) begin errors++; $display("FAIL fault_quiet got req=%0d gnt=%0d pops=%0d exp 0", req_seen, n_gnt - g0, pop_pc.size()); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        repeat (10) tick();
        checks++;
        if (pop_pc.size() < 2 || pop_pc[0] !== 32'h200 || pop_pc[1] !== 32'h204) begin
            errors++;
            $display("FAIL fault_exit got n=%0d first=%h exp 200,204", pop_pc.size(),
                     pop_pc.size() != 0 ? pop_pc[0] : 32'hx);
        end
    endtask

    task automatic test_halt();
        logic [31:0] pc_g;
        int g0;
        int req_seen;
        do_reset();
        lat_min = 3; lat_max = 3;
        imem_gnt = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 60 && n_gnt < 2; i++) tick();
        for (int i = 0; i < 60 && mq_addr.size() == 0; i++) tick();
        pc_g = last_gnt_addr;
        clear_pops();
        halt_i = 1'b1;
        g0 = n_gnt;
        req_seen = 0;
        repeat (12) begin tick(); if (s_req) req_seen++; end
        checks++; if (req_seen != 0 || n_gnt != g0) begin errors++; $display("FAIL halt_req got req=%0d gnt=%0d exp 0", req_seen, n_gnt - g0); end
        checks++; if (pop_pc.size() != 1 || pop_pc[0] !== pc_g) begin errors++; $display("FAIL halt_deliver got n=%0d exp 1 of pc=%h", pop_pc.size(), pc_g); end
        halt_i = 1'b0;
        clear_pops();
        repeat (12) tick();
        checks++;
        if (pop_pc.size() < 1 || pop_pc[0] !== pc_g + 32'd4) begin
            errors++;
            $display("FAIL halt_resume got n=%0d first=%h exp %h", pop_pc.size(),
                     pop_pc.size() != 0 ? pop_pc[0] : 32'hx, pc_g + 32'd4);
        end
    endtask

    task automatic test_wrap_and_rst();
        int g0;
        do_reset();
        lat_min = 1; lat_max = 1;
        imem_gnt = 1'b1;
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        repeat (12) tick();
        checks++;
        if (pop_pc.size() < 3 || pop_pc[0] !== 32'hFFFF_FFFC || pop_pc[1] !== 32'h0 || pop_pc[2] !== 32'h4) begin
            errors++;
            $display("FAIL wrap got n=%0d first=%h exp fffffffc,0,4", pop_pc.size(),
                     pop_pc.size() != 0 ? pop_pc[0] : 32'hx);
        end
        lat_min = 3; lat_max = 3;
        g0 = n_gnt;
        for (int i = 0; i < 20 && n_gnt == g0; i++) tick();
        checks++; if (n_gnt == g0) begin errors++; $display("FAIL rst_setup got no grant exp grant"); end
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        clear_pops();
        repeat (14) tick();
        checks++;
        if (pop_pc.size() < 2 || pop_pc[0] !== RESET_PC || pop_inst[0] !== memf(RESET_PC) || pop_pc[1] !== RESET_PC + 32'd4) begin
            errors++;
            $display("FAIL rst_restart got n=%0d first=%h exp %h", pop_pc.size(),
                     pop_pc.size() != 0 ? pop_pc[0] : 32'hx, RESET_PC);
        end
        checks++; if (proto_viol != 0) begin errors++; $display("FAIL protocol got=%0d violations exp 0", proto_viol); end
    endtask

    // Reference rule: after reset or an aligned redirect to X, decode must see
    // X, X+4, X+8, ... with inst = memory word at that PC, nothing skipped.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        int halt_left;
        int np;
        int n_ok;
        logic chk_flush;
        do_reset();
        lat_min = 1; lat_max = 4;
        exp_pc = RESET_PC;
        halt_left = 0;
        n_ok = 0;
        chk_flush = 1'b0;
        for (int t = 0; t < 800; t++) begin
            inst_ready = ($urandom_range(3, 0) != 0);
            imem_gnt = ($urandom_range(3, 0) != 0);
            if (halt_left > 0) halt_left--;
            else if ($urandom_range(40, 0) == 0) halt_left = int'($urandom_range(8, 1));
            halt_i = (halt_left > 0);
            tgt = 32'($urandom_range(255, 0)) << 2;
            redirect_valid = ($urandom_range(30, 0) == 0);
            redirect_pc = tgt;
            np = pop_pc.size();
            tick();
            if (chk_flush) begin
                checks++;
                if (s_valid !== 1'b0) begin errors++; $display("FAIL rand_flush t=%0d got valid=%b exp 0", t, s_valid); end
            end
            if (pop_pc.size() > np) begin
                checks++;
                if (pop_pc[np] !== exp_pc || pop_inst[np] !== memf(exp_pc)) begin
                    errors++;
                    $display("FAIL rand_pop t=%0d got pc=%h inst=%h exp pc=%h inst=%h", t,
                             pop_pc[np], pop_inst[np], exp_pc, memf(exp_pc));
                end else begin
                    n_ok++;
                end
                exp_pc = exp_pc + 32'd4;
            end
            chk_flush = redirect_valid;
            if (redirect_valid) exp_pc = tgt;
        end
        redirect_valid = 1'b0;
        halt_i = 1'b0;
        checks++; if (n_ok < 40) begin errors++; $display("FAIL rand_progress got=%0d exp>=40", n_ok); end
        checks++; if (proto_viol != 0) begin errors++; $display("FAIL rand_protocol got=%0d exp 0", proto_viol); end
    endtask

    initial begin
        rst = 1'b1;
        halt_i = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        inst_ready = 1'b0;
        last_gnt_addr = 32'h0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_fault();
        test_halt();
        test_wrap_and_rst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
